// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage between the program counter and decode. Issues one
//   single-beat read per instruction and hands the word to decode over
//   valid/ready. It also pulses the PC count enable once per accepted
//   fetch and discards in-flight reads on a flush. Misaligned PCs and
//   reads that time out latch a sticky fault, which only reset clears.
//
//   Parameter
//     FETCH_TIMEOUT   max wait cycles for busReady per request (0 = no timeout)
//   Ports
//     clk, reset      system clock, synchronous active-high reset
//     pcValue         current program counter
//     pcCountEnable   one-cycle pulse: PC advances by 4 at this edge
//     flush           control-flow change, PC rewritten this cycle
//     busAddress      read address (0 while no request)
//     busReadRequest  read request, held until busReady
//     busReady        read completes this cycle, busData valid
//     busData         read data
//     instrValid      instrData/instrPC valid towards decode
//     instrReady      decode accepts when instrValid && instrReady
//     instrData       fetched instruction word
//     instrPC         address the instruction came from
//     fetchFault      sticky fault flag
//
//   state | meaning
//   FETCH | request at pcValue, waiting for busReady
//   HOLD  | instruction presented to decode, waiting for transfer
//   DRAIN | flushed read still outstanding at old address, result dropped
//   FAULT | misaligned PC or bus timeout, parked until reset
module instruction_fetch #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcValue,
  output logic        pcCountEnable,
  input  logic        flush,
  output logic [31:0] busAddress,
  output logic        busReadRequest,
  input  logic        busReady,
  input  logic [31:0] busData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instrData,
  output logic [31:0] instrPC,
  output logic        fetchFault
);

  localparam logic [15:0] TIMEOUT = 16'(FETCH_TIMEOUT);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [31:0] fetch_addr;
  logic        load_instr;
  logic        clear_valid;
  logic        timeout;

  // Timeout only fires when busReady is low; a late completion in the
  // timeout cycle still wins.
  assign timeout = (TIMEOUT != 16'd0) && (wait_cnt == TIMEOUT) && !busReady;

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    busReadRequest = 1'b0;
    busAddress     = 32'd0;
    pcCountEnable  = 1'b0;
    load_instr     = 1'b0;
    clear_valid    = 1'b0;

    case (state)
      FETCH: begin
        if (pcValue[1:0] != 2'b00) begin
          state_nxt = FAULT;
        end else begin
          busReadRequest = 1'b1;
          busAddress     = pcValue;
          if (busReady) begin
            wait_cnt_nxt = 16'd0;
            // A flush in the completion cycle drops the data and leaves
            // the PC to the redirect.
            if (!flush) begin
              pcCountEnable = 1'b1;
              load_instr    = 1'b1;
              state_nxt     = HOLD;
            end
          end else if (flush) begin
            wait_cnt_nxt = 16'd0;
            state_nxt    = DRAIN;
          end else if (timeout) begin
            state_nxt = FAULT;
          end else begin
            wait_cnt_nxt = wait_cnt + 16'd1;
          end
        end
      end

      HOLD: begin
        if (flush || instrReady) begin
          clear_valid  = 1'b1;
          wait_cnt_nxt = 16'd0;
          state_nxt    = FETCH;
        end
      end

      DRAIN: begin
        // Keep the original address: the bus must see a stable request.
        busReadRequest = 1'b1;
        busAddress     = fetch_addr;
        if (busReady) begin
          wait_cnt_nxt = 16'd0;
          state_nxt    = FETCH;
        end else if (timeout) begin
          state_nxt = FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      FAULT: begin
      end

      default: begin
        state_nxt = FAULT;
      end
    endcase

    if (reset) begin
      busReadRequest = 1'b0;
      busAddress     = 32'd0;
      pcCountEnable  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= 16'd0;
      fetch_addr <= 32'd0;
      instrValid <= 1'b0;
      instrData  <= 32'd0;
      instrPC    <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == FETCH) begin
        fetch_addr <= pcValue;
      end
      if (load_instr) begin
        instrValid <= 1'b1;
        instrData  <= busData;
        instrPC    <= pcValue;
      end else if (clear_valid) begin
        instrValid <= 1'b0;
      end
    end
  end

  assign fetchFault = (state == FAULT);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of the program counter. Reads the current PC, issues a single-beat read on the instruction bus, and presents the returned word plus its address to decode over a valid/ready handshake. Pulses the PC's count enable once per accepted fetch, discards in-flight fetches on a control-flow flush, and traps misaligned or timed-out fetches.

## Interface
- FETCH_TIMEOUT, 255: max wait cycles for busReady per request; 0 disables the timeout; valid range 0..65535.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pcValue  in  32  current program counter value
- pcCountEnable  out  1  one-cycle pulse: PC advances by 4 at this edge
- flush  in  1  control-flow change; PC is being rewritten this cycle
- busAddress  out  32  instruction read address
- busReadRequest  out  1  read request, held until busReady
- busReady  in  1  read completes this cycle, busData valid
- busData  in  32  read data
- instrValid  out  1  instrData/instrPC valid
- instrReady  in  1  decode accepts when instrValid && instrReady
- instrData  out  32  fetched instruction word
- instrPC  out  32  address the instruction was fetched from
- fetchFault  out  1  sticky fault, cleared only by reset

## Operation
- States: FETCH, HOLD, DRAIN, FAULT. Reset state: FETCH.
- Reset values: instrValid 0, instrData 0, instrPC 0, fetchFault 0, wait counter 0. pcCountEnable and busReadRequest are forced to 0 while reset is high.
- FETCH:
  - If pcValue[1:0] != 0: no request is driven; go FAULT.
  - Otherwise busReadRequest=1 and busAddress=pcValue (combinational). fetchAddr <= pcValue every cycle.
  - On busReady && !flush: instrData<=busData, instrPC<=pcValue, instrValid<=1, pcCountEnable=1 this cycle (combinational), go HOLD.
- HOLD:
  - No request. instrValid=1; outputs stable until transfer.
  - On instrReady && !flush: instrValid<=0, go FETCH.
- DRAIN:
  - busReadRequest=1, busAddress=fetchAddr.
  - On busReady: data discarded, go FETCH.
- FAULT:
  - fetchFault=1, busReadRequest=0, instrValid=0.
  - flush and instrReady ignored; exits only on reset.
- Flush (priority over instrReady and busReady):
  - FETCH without busReady: go DRAIN.
  - FETCH with busReady: discard data, no pcCountEnable, go FETCH.
  - HOLD: instrValid<=0, go FETCH.
  - DRAIN: stay in DRAIN; flush has no extra effect.
- Wait counter (16-bit):
  - Cleared on entry to FETCH or DRAIN and on busReady; increments each request cycle without busReady.
  - If FETCH_TIMEOUT != 0 and counter reaches FETCH_TIMEOUT with busReady low: go FAULT, and the request drops at that edge.
  - busReady in the same cycle as the timeout wins and completes normally.
- busAddress is 0 whenever busReadRequest=0.

## Timing
- First request is in the first cycle after reset deasserts, at address 0.
- busReady seen in cycle N: instrValid is high from N+1. PC shows +4 from N+1.
- Transfer in cycle M: next request in M+1.
- Peak throughput: 1 instruction per 2 cycles with zero-wait memory.
- Flush in cycle F: instrValid is low from F+1. A new FETCH uses the rewritten pcValue from F+1, or after the drain completes.
- Bus rule: busReadRequest and busAddress stay constant from assertion until busReady is sampled.

## Test plan
- Zero-wait memory returning 0x00000013 at address 0, instrReady=1 → instrValid in cycle 2 with instrPC=0; pcCountEnable pulses exactly once per instruction; next request at address 4.
- busReady delayed 3 cycles, instrReady low for 5 cycles → request and address held stable; instrData/instrPC stable while stalled; exactly one pcCountEnable.
- flush in HOLD with instrReady=1 → no transfer; instrValid=0 next cycle; fetch resumes at new pcValue=0x100.
- flush two cycles into a pending request, busReady 2 cycles later → DRAIN keeps the old address; returned data never appears on instrData; then fetch at 0x100; no pcCountEnable for the drained read.
- pcValue=0x102 → no request issued; fetchFault=1 the next cycle and persists through flush until reset. Separately: FETCH_TIMEOUT=4 with busReady never asserted → fault after 4 wait cycles with the request dropped.
- reset asserted mid-HOLD → next cycle instrValid=0, fetchFault=0, state FETCH.
